student_serial_adder: RTL and testbench
=======================================

STUDENT_SERIAL_ADDER -- requirements
Module: student_serial_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits; legal range 1..32.
REQ-002 clk  input  1  rising-edge clock; all state changes on this edge only.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 start  input  1  request to begin one addition; sampled on rising clk.
REQ-005 a  input  WIDTH  operand A; sampled only on the edge that accepts start.
REQ-006 b  input  WIDTH  operand B; sampled only on the edge that accepts start.
REQ-007 busy  output  1  high while an addition is in progress; start is accepted only when low.
REQ-008 done  output  1  one-cycle pulse marking the cycle in which a new result is presented.
REQ-009 sum  output  WIDTH  registered result (a+b) mod 2^WIDTH.
REQ-010 car  output  1  registered carry-out of bit WIDTH-1.

Function
REQ-011 Datapath: one bit-serial full adder, built as two half-adder stages (sum = x^y^c; cout = x&y | c&(x^y)), reused over WIDTH cycles.
REQ-012 FSM states: IDLE, RUN, DONE; encoding is free; no other reachable states.
REQ-013 IDLE: busy=0, done=0; start=1 on an edge -> load a and b into shift registers, clear the carry flop, clear the bit counter, go to RUN.
REQ-014 RUN: busy=1, done=0. Each edge processes bit i = counter (LSB first), shifts the sum bit into the result register from the MSB end, updates the carry flop, and increments the counter.
REQ-015 RUN -> DONE on the edge that processes bit WIDTH-1. On that same edge, load the result into sum and the final carry into car.
REQ-016 DONE: busy=0, done=1 for exactly one cycle; the next edge goes to IDLE, or to RUN if start=1 (same load actions as REQ-013).
REQ-017 Latency: start accepted on edge E0 -> done high and sum/car valid in the cycle after edge E_WIDTH (WIDTH cycles after acceptance); throughput is one result per WIDTH+1 cycles.
REQ-018 start while busy=1 is ignored; it is neither queued nor does it affect the operation in flight.
REQ-019 a and b changes after acceptance do not affect the result.
REQ-020 sum and car hold their last values from the end of one operation until the next completion; they do not expose partial results during RUN.
REQ-021 The counter is ceil(log2(WIDTH+1)) bits wide or wider; no wrap occurs within an operation. WIDTH=1 completes in one RUN cycle.
REQ-022 No combinational path from any input to any output; busy and done are decoded from state registers only.

Reset
REQ-023 reset=1 on an edge -> state IDLE, busy=0, done=0, sum=0, car=0, carry flop=0, counter=0, shift registers=0.
REQ-024 reset has priority over start and over any in-flight operation; an operation aborted by reset produces no done pulse and leaves sum/car at 0.
REQ-025 The edge after reset is released accepts start normally.

Verification
REQ-026 WIDTH=16, a=0x0003, b=0x0005, start for 1 cycle -> busy=1 for 16 cycles, then done=1 for 1 cycle with sum=0x0008, car=0.
REQ-027 a=0xFFFF, b=0x0001 -> sum=0x0000, car=1; then a=0x8000, b=0x8000 -> sum=0x0000, car=1; then a=0x1234, b=0x4321 -> sum=0x5555, car=0.
REQ-028 start pulsed again 5 cycles into RUN with a=b=0xFFFF -> ignored; the original result appears on schedule, and exactly one done pulse occurs.
REQ-029 start held high continuously with a=0x0001, b=0x0001 -> a new operation starts in each DONE cycle, and done pulses every 17 cycles with sum=0x0002.
REQ-030 reset asserted 8 cycles into RUN -> the next cycle shows busy=0, done=0, sum=0, car=0, no done pulse; a fresh start afterwards yields the correct result.
REQ-031 WIDTH=1: the four (a,b) pairs 00/01/10/11 -> (sum,car)=00/10/10/01, each with done one cycle after acceptance.

Source files
------------

// File: rtl/student_serial_adder.sv
// Bit-serial adder: one full adder reused over WIDTH cycles, LSB first.
// The operand-A shift register doubles as the result register.
module student_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             car
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             ha1_s, ha1_c, fa_s, fa_c;
    logic [WIDTH-1:0] sh_a_next;

    // Two half-adder stages form the single full adder.
    assign ha1_s = sh_a[0] ^ sh_b[0];
    assign ha1_c = sh_a[0] & sh_b[0];
    assign fa_s  = ha1_s ^ carry;
    assign fa_c  = ha1_c | (ha1_s & carry);

    // Sum bits enter from the MSB end as operand bits leave from the LSB end.
    generate
        if (WIDTH == 1) begin : g_w1
            assign sh_a_next = fa_s;
        end else begin : g_wn
            assign sh_a_next = {fa_s, sh_a[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            car   <= 1'b0;
            carry <= 1'b0;
            cnt   <= '0;
            sh_a  <= '0;
            sh_b  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        carry <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    sh_a  <= sh_a_next;
                    sh_b  <= sh_b >> 1;
                    carry <= fa_c;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum   <= sh_a_next;
                        car   <= fa_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        carry <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_student_serial_adder.sv
// Scoreboard bench for student_serial_adder at WIDTH=16 and WIDTH=1.
module tb_student_serial_adder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, car;
    logic [15:0] sum;

    logic        start1 = 1'b0;
    logic [0:0]  a1 = '0, b1 = '0;
    logic        busy1, done1, car1;
    logic [0:0]  sum1;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] s;
        logic        c;
        int          due;
    } exp_t;

    exp_t q16[$];
    exp_t q1[$];
    logic [15:0] hold16 = '0;
    logic        holdc16 = 1'b0;
    logic [0:0]  hold1 = '0;
    logic        holdc1 = 1'b0;
    bit          skip_hold = 1'b1;

    student_serial_adder #(.WIDTH(16)) u16 (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .car(car)
    );

    student_serial_adder #(.WIDTH(1)) u1 (
        .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .car(car1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop an expectation on every done pulse, otherwise results must hold.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q16.size() == 0) begin
                chk("w16_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q16.pop_front();
                chk("w16_sum", sum, e.s);
                chk("w16_car", car, e.c);
                chk("w16_latency", cyc, e.due);
                hold16 = e.s;
                holdc16 = e.c;
            end
        end else if (!skip_hold) begin
            chk("w16_sum_hold", sum, hold16);
            chk("w16_car_hold", car, holdc16);
        end
    end

    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("w1_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("w1_sum", sum1, e.s);
                chk("w1_car", car1, e.c);
                chk("w1_latency", cyc, e.due);
                hold1 = e.s[0];
                holdc1 = e.c;
            end
        end else if (!skip_hold) begin
            chk("w1_sum_hold", sum1, hold1);
            chk("w1_car_hold", car1, holdc1);
        end
    end

    function automatic exp_t model16(input logic [15:0] x, input logic [15:0] y, input int due);
        exp_t e;
        int unsigned t;
        t = int'(x) + int'(y);
        e.s = t[15:0];
        e.c = (t >= 65536);
        e.due = due;
        return e;
    endfunction

    task automatic wait_empty16(input string name);
        int n = 0;
        while (q16.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (q16.size() != 0) begin
            chk({name, "_timeout"}, q16.size(), 0);
            q16.delete();
        end
    endtask

    // Issue one op (caller sits 1 time unit after a rising edge). Optionally
    // poke a second start while busy, which must be ignored.
    task automatic op16(input logic [15:0] x, input logic [15:0] y, input int poke_at);
        start = 1'b1; a = x; b = y;
        q16.push_back(model16(x, y, cyc + 1 + 16));
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        chk("w16_busy_after_accept", busy, 1);
        if (poke_at > 0) begin
            repeat (poke_at - 1) @(posedge clk);
            #1;
            start = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
            @(posedge clk); #1;
            start = 1'b0;
            chk("w16_busy_during_run", busy, 1);
        end
        wait_empty16("w16_op");
    endtask

    task automatic op1(input logic x, input logic y);
        exp_t e;
        start1 = 1'b1; a1 = x; b1 = y;
        e.s = {15'd0, x ^ y};
        e.c = x & y;
        e.due = cyc + 2;
        q1.push_back(e);
        @(posedge clk); #1;
        start1 = 1'b0;
        a1 = ~x; b1 = ~y;
        begin
            int n = 0;
            while (q1.size() != 0 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            if (q1.size() != 0) begin
                chk("w1_timeout", q1.size(), 0);
                q1.delete();
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_car", car, 0);
        chk("rst_w1_sum", sum1, 0);
        skip_hold = 1'b0;

        op16(16'h0003, 16'h0005, 0);
        op16(16'hFFFF, 16'h0001, 0);
        op16(16'h8000, 16'h8000, 0);
        op16(16'h1234, 16'h4321, 0);
        op16(16'h0003, 16'h0005, 5);
        repeat (20) @(posedge clk);
        #1;

        // Start held high: an op is accepted in each DONE cycle, period 17.
        start = 1'b1; a = 16'h0001; b = 16'h0001;
        for (int i = 0; i < 4; i++) q16.push_back(model16(16'h1, 16'h1, cyc + 17 + 17 * i));
        repeat (52) @(posedge clk);
        #1;
        start = 1'b0;
        wait_empty16("w16_held");
        repeat (5) @(posedge clk);
        #1;

        // Reset 8 cycles into RUN aborts the op with no done pulse.
        start = 1'b1; a = 16'h00F0; b = 16'h0F0F;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        skip_hold = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", sum, 0);
        chk("abort_car", car, 0);
        hold16 = '0; holdc16 = 1'b0;
        hold1 = '0; holdc1 = 1'b0;
        skip_hold = 1'b0;
        op16(16'h1111, 16'h2222, 0);

        for (int i = 0; i < 25; i++) begin
            logic [15:0] x, y;
            x = 16'($urandom);
            y = 16'($urandom);
            if (i % 5 == 0) x = 16'hFFFF;
            op16(x, y, (i % 7 == 3) ? 1 + (i % 14) : 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        op1(1'b0, 1'b0);
        op1(1'b0, 1'b1);
        op1(1'b1, 1'b0);
        op1(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) op1(1'($urandom), 1'($urandom));

        repeat (20) @(posedge clk);
        #1;
        chk("final_queue16_empty", q16.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
